// File: rtl/rfu_pkg.sv
// Shared definitions for the register-fetch/bypass stage.
// No logic state; widths and the forwarding match helper only.
// Used by both the operand selector and the stage top.
package rfu_pkg;

  localparam int REG_AW   = 5;
  localparam int CSR_AW   = 12;
  localparam int NSRC_DEF = 3;

  // A forwarding source matches when it holds a GPR writer targeting rs.
  function automatic logic fwd_match(input logic              vld,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return vld && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Resolves one GPR operand against the in-flight forwarding sources.
// Purely combinational, zero latency.
// Raises hazard when the youngest matching producer has no data yet.
module fwd_sel
  import rfu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = NSRC_DEF
) (
  input  logic                   en,
  input  logic [REG_AW-1:0]      rs,
  input  logic [XLEN-1:0]        rf_value,
  input  logic [NSRC-1:0]        fwd_valid,
  input  logic [REG_AW*NSRC-1:0] fwd_rd,
  input  logic [NSRC-1:0]        fwd_data_ok,
  input  logic [XLEN*NSRC-1:0]   fwd_data,
  output logic [XLEN-1:0]        value,
  output logic                   hazard
);

  logic            hit;
  logic            hit_ok;
  logic [XLEN-1:0] hit_data;

  // Walk oldest to youngest so the lowest-index (youngest) match wins,
  // then pick forwarded data, register-file data, or flag a hazard.
  always_comb begin
    hit      = 1'b0;
    hit_ok   = 1'b0;
    hit_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (fwd_match(fwd_valid[i], fwd_rd[i*REG_AW +: REG_AW], rs)) begin
        hit      = 1'b1;
        hit_ok   = fwd_data_ok[i];
        hit_data = fwd_data[i*XLEN +: XLEN];
      end
    end
    value  = rf_value;
    hazard = 1'b0;
    // x0 and unread operands never forward and never stall.
    if (en && (rs != '0) && hit) begin
      if (hit_ok) begin
        value = hit_data;
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rfu_bypass.sv
// Register-fetch stage: latches one decoded entry, reads GPR/CSR, forwards GPRs.
// 1 cycle accept-to-issue; outputs combinational from entry and forwarding.
// Stalls (in_ready=0, out_valid=0) on unresolved GPR or any CSR hazard.
module rfu_bypass
  import rfu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = NSRC_DEF,
  parameter int PAY_W = 128,
  parameter int CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_AW-1:0]      in_rs1,
  input  logic [REG_AW-1:0]      in_rs2,
  input  logic                   in_rs1_en,
  input  logic                   in_rs2_en,
  input  logic [CSR_AW-1:0]      in_csr_addr,
  input  logic                   in_csr_en,
  input  logic [PAY_W-1:0]       in_payload,
  output logic [REG_AW-1:0]      rf_rs1_o,
  output logic [REG_AW-1:0]      rf_rs2_o,
  input  logic [XLEN-1:0]        rf_rs1_value_i,
  input  logic [XLEN-1:0]        rf_rs2_value_i,
  output logic [CSR_AW-1:0]      csr_addr_o,
  input  logic [XLEN-1:0]        csr_value_i,
  input  logic [NSRC-1:0]        fwd_valid,
  input  logic [REG_AW*NSRC-1:0] fwd_rd,
  input  logic [NSRC-1:0]        fwd_data_ok,
  input  logic [XLEN*NSRC-1:0]   fwd_data,
  input  logic [NSRC-1:0]        fwd_csr_we,
  input  logic [CSR_AW*NSRC-1:0] fwd_csr_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_src1,
  output logic [XLEN-1:0]        out_src2,
  output logic [XLEN-1:0]        out_csr,
  output logic [PAY_W-1:0]       out_payload,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic              rs1_en_q, rs1_en_d, rs2_en_q, rs2_en_d;
  logic [CSR_AW-1:0] csr_addr_q, csr_addr_d;
  logic              csr_en_q, csr_en_d;
  logic [PAY_W-1:0]  payload_q, payload_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0]   src1_val, src2_val;
  logic              rs1_hazard, rs2_hazard;
  logic              csr_hit, stall, accept;

  fwd_sel #(.XLEN(XLEN), .NSRC(NSRC)) u_fwd_rs1 (
    .en(rs1_en_q), .rs(rs1_q), .rf_value(rf_rs1_value_i),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data_ok(fwd_data_ok),
    .fwd_data(fwd_data), .value(src1_val), .hazard(rs1_hazard)
  );

  fwd_sel #(.XLEN(XLEN), .NSRC(NSRC)) u_fwd_rs2 (
    .en(rs2_en_q), .rs(rs2_q), .rf_value(rf_rs2_value_i),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data_ok(fwd_data_ok),
    .fwd_data(fwd_data), .value(src2_val), .hazard(rs2_hazard)
  );

  // Handshake, hazard detection and next-state for the entry and counter.
  always_comb begin
    // CSRs are never forwarded: any in-flight writer to the same CSR stalls.
    csr_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (fwd_valid[i] && fwd_csr_we[i] &&
          (fwd_csr_addr[i*CSR_AW +: CSR_AW] == csr_addr_q)) begin
        csr_hit = 1'b1;
      end
    end
    stall     = valid_q && (rs1_hazard || rs2_hazard || (csr_en_q && csr_hit));
    out_valid = valid_q && !stall && !flush;
    in_ready  = !valid_q || (out_ready && !stall && !flush);
    accept    = in_valid && in_ready;

    rs1_d      = accept ? in_rs1      : rs1_q;
    rs2_d      = accept ? in_rs2      : rs2_q;
    rs1_en_d   = accept ? in_rs1_en   : rs1_en_q;
    rs2_en_d   = accept ? in_rs2_en   : rs2_en_q;
    csr_addr_d = accept ? in_csr_addr : csr_addr_q;
    csr_en_d   = accept ? in_csr_en   : csr_en_q;
    payload_d  = accept ? in_payload  : payload_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Control state: cleared asynchronously so a reset mid-stall drops the entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Entry payload/index fields need no reset; outputs are gated by valid.
  always_ff @(posedge clock) begin
    rs1_q      <= rs1_d;
    rs2_q      <= rs2_d;
    rs1_en_q   <= rs1_en_d;
    rs2_en_q   <= rs2_en_d;
    csr_addr_q <= csr_addr_d;
    csr_en_q   <= csr_en_d;
    payload_q  <= payload_d;
  end

  assign rf_rs1_o    = valid_q ? rs1_q      : '0;
  assign rf_rs2_o    = valid_q ? rs2_q      : '0;
  assign csr_addr_o  = valid_q ? csr_addr_q : '0;
  assign out_src1    = valid_q ? src1_val   : '0;
  assign out_src2    = valid_q ? src2_val   : '0;
  assign out_csr     = valid_q ? csr_value_i : '0;
  assign out_payload = valid_q ? payload_q  : '0;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/rfu_bypass.md
# rfu_bypass

Parametrised register-fetch stage sitting between decode and execute. It latches one decoded instruction and reads the GPR and CSR files. GPR operands are forwarded from up to NSRC younger in-flight pipeline stages, and the stage stalls only when the youngest matching producer has no result yet. CSR hazards always stall. Unlike the previous fetch stage, it ignores x0 and per-operand unused sources, and it counts stall cycles.

## Interface
Parameters:
- XLEN, 32, data width of GPR/CSR values
- NSRC, 3, number of forwarding sources; index 0 = youngest (EXU), NSRC-1 = oldest (WBU)
- PAY_W, 128, width of opaque decode payload passed through unchanged
- CNT_W, 32, stall-counter width

Ports (clock `clock`, reset `reset`: one clock; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  async active-high reset
- flush  in  1  branch/exception/mret flush, OR-combined upstream
- in_valid  in  1  decode entry valid
- in_ready  out  1  stage can accept
- in_rs1, in_rs2  in  5  source register indices
- in_rs1_en, in_rs2_en  in  1  operand actually read
- in_csr_addr  in  12  CSR index
- in_csr_en  in  1  instruction reads a CSR
- in_payload  in  PAY_W  pass-through decode fields
- rf_rs1_o, rf_rs2_o  out  5  GPR read addresses (from latched entry)
- rf_rs1_value_i, rf_rs2_value_i  in  XLEN  GPR read data, combinational
- csr_addr_o  out  12  CSR read address
- csr_value_i  in  XLEN  CSR read data
- fwd_valid  in  NSRC  source holds a GPR-writing instruction
- fwd_rd  in  5*NSRC  destination register per source
- fwd_data_ok  in  NSRC  result available this cycle (0 for a load before LSU completes)
- fwd_data  in  XLEN*NSRC  result per source
- fwd_csr_we  in  NSRC  source writes a CSR
- fwd_csr_addr  in  12*NSRC  CSR destination per source
- out_valid  out  1  operands resolved and entry issuable
- out_ready  in  1  execute stage accepts
- out_src1, out_src2  out  XLEN  resolved rs1/rs2 values
- out_csr  out  XLEN  CSR read value
- out_payload  out  PAY_W  latched payload
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Entry register fields: valid, rs1, rs2, rs1_en, rs2_en, csr_addr, csr_en, payload. Loaded when in_valid && in_ready.
- Per operand k with en=1 and rs≠0: find the lowest index i with fwd_valid[i] && fwd_rd[i]==rs.
  - Match with fwd_data_ok[i]=1: value = fwd_data[i].
  - Match with fwd_data_ok[i]=0: operand hazard.
  - No match: value = rf value.
- Operand with rs==0 or en=0: value = rf value (x0 reads 0). Never causes a hazard.
- CSR hazard: csr_en && any i with fwd_valid[i] && fwd_csr_we[i] && fwd_csr_addr[i]==csr_addr. There is no CSR forwarding.
- stall = valid && (rs1 hazard || rs2 hazard || csr hazard).
- out_valid = valid && !stall && !flush.
- in_ready = !valid || (out_ready && !stall && !flush). A flush blocks acceptance in the same cycle.
- valid next state, in priority order:
  1. flush → 0
  2. accept → 1
  3. out_valid && out_ready → 0
  4. otherwise hold
- stall_cnt increments when valid && stall && !flush. It saturates at all-ones and never wraps.

## Timing
- Reset values: valid=0, stall_cnt=0. Hence out_valid=0 and in_ready=1. Payload/index registers are don't-care but must not reach the outputs while valid=0.
- Latency: 1 cycle from accept to out_valid when no hazard. All out_* fields are combinational from the entry and the forwarding inputs in the same cycle.
- Back-to-back issue: accept and issue in the same cycle sustain 1 instruction per cycle.
- A hazard holds out_valid=0 and in_ready=0. The entry is re-evaluated every cycle, so it resolves the cycle the youngest producer raises data_ok or leaves the pipe.
- Reset asserted mid-stall clears valid immediately (async).

## Structure
- Shared package `rfu_pkg` holds:
  - REG_AW=5 and CSR_AW=12
  - function `fwd_match`
  - the default NSRC
- Sub-module `fwd_sel` resolves one operand: priority match, value select, hazard flag. It is parameterised on XLEN/NSRC and instantiated twice (rs1, rs2).
- The CSR hazard OR-reduction stays inline.

## Test plan
- No hazard: rs1=3, rs2=4, rf values 0x11/0x22, fwd_valid=0 → out_src1=0x11, out_src2=0x22 one cycle after accept; 4 back-to-back instructions issue on 4 consecutive cycles.
- Priority: rs1=5; src0 rd=5 data 0xAAAA ok; src2 rd=5 data 0xBBBB ok → out_src1=0xAAAA, no stall.
- Load-use: src0 rd=7, data_ok=0 for 2 cycles then 1 with 0x1234 → out_valid low 2 cycles, stall_cnt=2, then issues with out_src1=0x1234.
- x0 and unused operands:
  - rs2=0 with src0 rd=0 not ok → no stall.
  - rs1_en=0 matching a not-ok source → no stall.
- CSR: csr_en, addr 0x300, src1 csr_we to 0x300 → stall until src1 fwd_valid drops; out_csr = csr_value_i after.
- Flush during stall with in_valid=1 → next cycle valid=0, no accept that cycle; stall_cnt stops; with CNT_W=4 preloaded by 20 stall cycles, stall_cnt=15.
